// File: rtl/reflet_power_manager_ext_pkg.sv
// Shared definitions for the Reflet power manager: register offsets,
// CTRL/STATUS field layout, power-state encoding and register-window size.
package reflet_power_manager_ext_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'd0;
  localparam logic [3:0] OFF_POWER  = 4'd1;
  localparam logic [3:0] OFF_MASK   = 4'd2;
  localparam logic [3:0] OFF_STATUS = 4'd3;
  localparam logic [3:0] OFF_RELOAD = 4'd4;

  localparam int CTRL_SLEEP = 0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOWPOWER = 2'd1,
    ST_SLEEP    = 2'd2
  } pm_state_t;

  // Bit 0 is the last member of each struct.
  typedef struct packed {
    logic timer_en;
    logic lowpower;
    logic sleep;
  } ctrl_t;

  typedef struct packed {
    logic by_ctrl;
    logic by_timer;
    logic by_irq;
  } status_t;

  function automatic int unsigned reg_count(input int unsigned timer_width);
    return 4 + timer_width / 8;
  endfunction

endpackage

// File: rtl/reflet_power_manager_ext_if.sv
// Byte-wide peripheral bus seen by the power manager.
// Reads are combinational; writes land on the sampling edge; no backpressure.
interface reflet_power_manager_ext_if #(
  parameter int unsigned addr_w = 16
);
  logic              enable;
  logic [addr_w-1:0] addr;
  logic              write_en;
  logic [7:0]        data_in;
  logic [7:0]        data_out;

  modport master (output enable, addr, write_en, data_in, input data_out);
  modport slave  (input enable, addr, write_en, data_in, output data_out);
endinterface

// File: rtl/reflet_power_wake_timer.sv
// Prescaled, reloadable down-counter for timed wake from sleep.
// expired is combinational in the tick cycle where the count is already 0; no backpressure.
module reflet_power_wake_timer #(
  parameter int unsigned timer_width = 16,
  parameter int unsigned prescale    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [timer_width-1:0] load_val,
  input  logic                   en,
  output logic                   expired
);
  localparam int unsigned PW = (prescale > 1) ? $clog2(prescale) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(prescale - 1);

  logic [PW-1:0]          pre_q, pre_d;
  logic [timer_width-1:0] cnt_q, cnt_d;
  logic                   tick;

  assign tick    = en && (pre_q == PRE_LAST);
  assign expired = tick && (cnt_q == '0);

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load) begin
      pre_d = '0;
      cnt_d = load_val;
    end else if (en) begin
      if (tick) begin
        pre_d = '0;
        // Holding at zero keeps expired asserted until the FSM leaves sleep.
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reflet_power_manager_ext.sv
// Reflet power manager: sleep until masked interrupt / wake timer / CTRL write, or PWM-throttle the CPU.
// Register writes act at the sampling edge, cpu_enable follows one cycle later; bus has no backpressure.
module reflet_power_manager_ext
  import reflet_power_manager_ext_pkg::*;
#(
  parameter int unsigned               base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF1F,
  parameter int unsigned               int_count      = 4,
  parameter int unsigned               timer_width    = 16,
  parameter int unsigned               prescale       = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  reflet_power_manager_ext_if.slave bus,
  input  logic [int_count-1:0]     cpu_interrupts,
  output logic                     cpu_enable,
  output logic                     sleeping
);
  localparam int NBYTES = int'(timer_width / 8);
  localparam logic [base_addr_size-1:0] NREG = base_addr_size'(reg_count(timer_width));

  logic [base_addr_size-1:0] offset;
  logic [3:0]                idx;
  logic                      sel;
  logic                      wr;
  logic                      wr_ctrl;
  logic                      wr_status;
  logic [7:0]                rd_dat;

  pm_state_t              state_q, state_d;
  ctrl_t                  ctrl_q, ctrl_d;
  status_t                status_q, status_d;
  status_t                wake;
  logic [7:0]             power_q, power_d;
  logic [int_count-1:0]   mask_q, mask_d;
  logic [timer_width-1:0] reload_q, reload_d;
  logic [7:0]             pwm_cnt_q, pwm_cnt_d;
  logic                   pwm_out;
  logic                   timer_load;
  logic                   timer_en;
  logic                   tmr_expired;

  // Addresses below base_addr wrap to large offsets and fall outside the window.
  assign offset    = bus.addr - base_addr;
  assign sel       = bus.enable && (offset < NREG);
  assign idx       = offset[3:0];
  assign wr        = sel && bus.write_en;
  assign wr_ctrl   = wr && (idx == OFF_CTRL);
  assign wr_status = wr && (idx == OFF_STATUS);

  // Plain data registers and the free-running PWM counter.
  always_comb begin
    power_d   = power_q;
    mask_d    = mask_q;
    reload_d  = reload_q;
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    if (wr && idx == OFF_POWER) power_d = bus.data_in;
    if (wr && idx == OFF_MASK)  mask_d  = bus.data_in[int_count-1:0];
    for (int i = 0; i < NBYTES; i++) begin
      if (wr && idx == OFF_RELOAD + 4'(i)) reload_d[8*i +: 8] = bus.data_in;
    end
  end

  assign pwm_out = (pwm_cnt_q <= power_q);

  // Power-state FSM; owns CTRL and STATUS because wake events modify both.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    status_d   = status_q;
    wake       = '0;
    timer_load = 1'b0;
    if (wr_ctrl)   ctrl_d   = ctrl_t'(bus.data_in[2:0]);
    if (wr_status) status_d = status_q & ~status_t'(bus.data_in[2:0]);
    case (state_q)
      ST_SLEEP: begin
        wake.by_irq   = |(mask_q & cpu_interrupts);
        wake.by_timer = tmr_expired;
        wake.by_ctrl  = wr_ctrl && !bus.data_in[CTRL_SLEEP];
        if (|wake) begin
          ctrl_d.sleep = 1'b0;
          state_d      = ctrl_d.lowpower ? ST_LOWPOWER : ST_RUN;
        end
      end
      default: begin
        if (wr_ctrl && bus.data_in[CTRL_SLEEP]) begin
          state_d    = ST_SLEEP;
          timer_load = 1'b1;
        end else begin
          state_d = ctrl_d.lowpower ? ST_LOWPOWER : ST_RUN;
        end
      end
    endcase
    // Wake causes are OR-ed after the W1C so a same-cycle set always survives.
    status_d = status_d | wake;
  end

  assign timer_en = (state_q == ST_SLEEP) && ctrl_q.timer_en;

  reflet_power_wake_timer #(
    .timer_width (timer_width),
    .prescale    (prescale)
  ) u_wake_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (reload_q),
    .en       (timer_en),
    .expired  (tmr_expired)
  );

  always_comb begin
    rd_dat = 8'h00;
    case (idx)
      OFF_CTRL:   rd_dat = {5'b0, ctrl_q};
      OFF_POWER:  rd_dat = power_q;
      OFF_MASK:   rd_dat = 8'(mask_q);
      OFF_STATUS: rd_dat = {5'b0, status_q};
      default: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx == OFF_RELOAD + 4'(i)) rd_dat = reload_q[8*i +: 8];
        end
      end
    endcase
  end

  assign bus.data_out = sel ? rd_dat : 8'h00;

  always_comb begin
    cpu_enable = 1'b1;
    case (state_q)
      ST_LOWPOWER: cpu_enable = pwm_out;
      ST_SLEEP:    cpu_enable = 1'b0;
      default:     cpu_enable = 1'b1;
    endcase
  end

  assign sleeping = (state_q == ST_SLEEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      ctrl_q    <= '0;
      status_q  <= '0;
      power_q   <= 8'hFF;
      mask_q    <= '0;
      reload_q  <= '0;
      pwm_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      power_q   <= power_d;
      mask_q    <= mask_d;
      reload_q  <= reload_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

endmodule

// File: tb/tb_reflet_power_manager_ext.sv
// Bench for reflet_power_manager_ext: two instances (prescale 1 and 4) share one bus stimulus
// and are checked every cycle against a cycle-count-based reference model.
module tb_reflet_power_manager_ext;

  localparam logic [15:0] BASE = 16'hFF1F;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          t_en = 1'b0;
  logic          t_we = 1'b0;
  logic [15:0]   t_addr = 16'h0000;
  logic [7:0]    t_din = 8'h00;
  logic [NI-1:0] t_irq = '0;
  logic [1:0]    cpu_en;
  logic [1:0]    slp;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state, one copy per instance.
  logic [2:0]  m_ctrl [2];
  logic [2:0]  m_status [2];
  logic [7:0]  m_power [2];
  logic [3:0]  m_mask [2];
  logic [15:0] m_reload [2];
  bit          m_sleep [2];
  int          m_k [2];
  int          m_dl [2];
  int          m_cyc;
  logic        seen_en [2];

  always #5 clk = ~clk;

  reflet_power_manager_ext_if #(.addr_w(16)) bus1 ();
  reflet_power_manager_ext_if #(.addr_w(16)) bus4 ();

  assign bus1.enable = t_en;
  assign bus1.addr = t_addr;
  assign bus1.write_en = t_we;
  assign bus1.data_in = t_din;
  assign bus4.enable = t_en;
  assign bus4.addr = t_addr;
  assign bus4.write_en = t_we;
  assign bus4.data_in = t_din;

  reflet_power_manager_ext #(
    .base_addr_size (16), .base_addr (BASE), .int_count (NI), .timer_width (16), .prescale (1)
  ) dut_p1 (
    .clk (clk), .reset (rst_n), .bus (bus1), .cpu_interrupts (t_irq),
    .cpu_enable (cpu_en[0]), .sleeping (slp[0])
  );

  reflet_power_manager_ext #(
    .base_addr_size (16), .base_addr (BASE), .int_count (NI), .timer_width (16), .prescale (4)
  ) dut_p4 (
    .clk (clk), .reset (rst_n), .bus (bus4), .cpu_interrupts (t_irq),
    .cpu_enable (cpu_en[1]), .sleeping (slp[1])
  );

  function automatic int ps_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [7:0] dout(input int d);
    return (d == 0) ? bus1.data_out : bus4.data_out;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_ctrl[d] = 3'd0;
      m_status[d] = 3'd0;
      m_power[d] = 8'hFF;
      m_mask[d] = 4'd0;
      m_reload[d] = 16'd0;
      m_sleep[d] = 1'b0;
      m_k[d] = 0;
      m_dl[d] = 0;
    end
    m_cyc = 0;
  endtask

  function automatic logic [7:0] m_read(input int d);
    logic [15:0] off;
    off = t_addr - BASE;
    if (!t_en || off > 16'd5) return 8'h00;
    case (off[2:0])
      3'd0: return {5'b0, m_ctrl[d]};
      3'd1: return m_power[d];
      3'd2: return {4'b0, m_mask[d]};
      3'd3: return {5'b0, m_status[d]};
      3'd4: return m_reload[d][7:0];
      default: return m_reload[d][15:8];
    endcase
  endfunction

  // Expected CPU enable: PWM phase is simply the number of edges since reset, mod 256.
  function automatic logic exp_en(input int d);
    logic [7:0] phase;
    phase = m_cyc[7:0];
    if (m_sleep[d]) return 1'b0;
    if (m_ctrl[d][1]) return (phase <= m_power[d]);
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [15:0] off;
    logic wr, iw, tw, cw;
    logic [2:0] nctrl;
    off = t_addr - BASE;
    wr = t_en && t_we && (off < 16'd6);
    for (int d = 0; d < 2; d++) begin
      iw = 1'b0; tw = 1'b0; cw = 1'b0;
      nctrl = (wr && off == 16'd0) ? t_din[2:0] : m_ctrl[d];
      if (m_sleep[d]) begin
        m_k[d] = m_k[d] + 1;
        iw = |(m_mask[d] & t_irq);
        tw = m_ctrl[d][2] && (m_k[d] == m_dl[d]);
        cw = wr && (off == 16'd0) && !t_din[0];
      end
      if (wr && off == 16'd3) m_status[d] = m_status[d] & ~t_din[2:0];
      m_status[d] = m_status[d] | {cw, tw, iw};
      if (m_sleep[d] && (iw || tw || cw)) begin
        nctrl[0] = 1'b0;
        m_sleep[d] = 1'b0;
      end else if (!m_sleep[d] && wr && off == 16'd0 && t_din[0]) begin
        m_sleep[d] = 1'b1;
        m_k[d] = 0;
        m_dl[d] = (int'(m_reload[d]) + 1) * ps_of(d);
      end
      if (wr && off == 16'd1) m_power[d] = t_din;
      if (wr && off == 16'd2) m_mask[d] = t_din[3:0];
      if (wr && off == 16'd4) m_reload[d][7:0] = t_din;
      if (wr && off == 16'd5) m_reload[d][15:8] = t_din;
      m_ctrl[d] = nctrl;
    end
    m_cyc = m_cyc + 1;
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, d, obs, exp);
    end
  endtask

  // One bus cycle: drive, check pre-edge outputs against the model, clock, advance model.
  task automatic step(input logic en, input logic [15:0] a, input logic we,
                      input logic [7:0] din, input logic [NI-1:0] irq);
    t_en = en; t_addr = a; t_we = we; t_din = din; t_irq = irq;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("cpu_enable", d, 32'(cpu_en[d]), 32'(exp_en(d)));
      chk("sleeping", d, 32'(slp[d]), 32'(m_sleep[d]));
      chk("data_out", d, 32'(dout(d)), 32'(m_read(d)));
      seen_en[d] = cpu_en[d];
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [3:0] off, input logic [7:0] dat, input logic [NI-1:0] irq);
    step(1'b1, BASE + 16'(off), 1'b1, dat, irq);
  endtask

  task automatic idle(input logic [NI-1:0] irq);
    step(1'b0, 16'h0000, 1'b0, 8'h00, irq);
  endtask

  task automatic expect_rd(input int d, input logic [3:0] off, input logic [7:0] exp, input string tag);
    t_en = 1'b1; t_we = 1'b0; t_addr = BASE + 16'(off); t_irq = '0;
    #1;
    chk(tag, d, 32'(dout(d)), 32'(exp));
  endtask

  initial begin
    logic [7:0] rv [6];
    int low [2];
    int high [2];
    logic [NI-1:0] r_irq;
    int r;
    logic [3:0] r_off;
    logic [7:0] r_dat;

    rv[0] = 8'h00; rv[1] = 8'hFF; rv[2] = 8'h00; rv[3] = 8'h00; rv[4] = 8'h00; rv[5] = 8'h00;
    m_reset();

    // Reset state.
    #2 rst_n = 1'b0;
    #20;
    for (int d = 0; d < 2; d++) begin
      chk("rst_cpu_enable", d, 32'(cpu_en[d]), 32'd1);
      chk("rst_sleeping", d, 32'(slp[d]), 32'd0);
      for (int o = 0; o < 4; o++) expect_rd(d, 4'(o), rv[o], "rst_reg");
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    // Masked interrupt wake.
    wr(4'd2, 8'h02, 4'h0);
    wr(4'd0, 8'h01, 4'h0);
    idle(4'b0001);
    chk("masked_irq_ignored", 0, 32'(slp[0]), 32'd1);
    idle(4'b0010);
    chk("irq_wake_en", 0, 32'(cpu_en[0]), 32'd1);
    expect_rd(0, 4'd3, 8'h01, "irq_status");
    expect_rd(0, 4'd0, 8'h00, "irq_ctrl_cleared");

    // Timer-only sleep length for both prescales.
    wr(4'd3, 8'h07, 4'h0);
    wr(4'd4, 8'h09, 4'h0);
    wr(4'd5, 8'h00, 4'h0);
    wr(4'd0, 8'h05, 4'h0);
    low[0] = 0; low[1] = 0;
    for (int i = 0; i < 60; i++) begin
      idle(4'h0);
      for (int d = 0; d < 2; d++) if (!seen_en[d]) low[d]++;
    end
    chk("sleep_len_p1", 0, 32'(low[0]), 32'd10);
    chk("sleep_len_p4", 1, 32'(low[1]), 32'd40);
    expect_rd(0, 4'd3, 8'h02, "timer_status");
    expect_rd(1, 4'd3, 8'h02, "timer_status");

    // PWM duty, then sleep and wake back into low-power.
    wr(4'd0, 8'h02, 4'h0);
    wr(4'd1, 8'h3F, 4'h0);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        wr(4'd0, 8'h03, 4'h0);
        idle(4'b0010);
      end
      high[0] = 0; high[1] = 0;
      for (int i = 0; i < 256; i++) begin
        idle(4'h0);
        for (int d = 0; d < 2; d++) if (seen_en[d]) high[d]++;
      end
      chk("pwm_duty", 0, 32'(high[0]), 32'd64);
      chk("pwm_duty", 1, 32'(high[1]), 32'd64);
    end

    // Interrupt already pending at entry: exactly one sleep cycle.
    wr(4'd3, 8'h07, 4'h0);
    wr(4'd0, 8'h01, 4'b0010);
    idle(4'b0010);
    chk("pending_sleep_cycle", 0, 32'(seen_en[0]), 32'd0);
    idle(4'h0);
    chk("pending_woken", 0, 32'(seen_en[0]), 32'd1);

    // Interrupt and timer expiry on the same edge, then W1C.
    wr(4'd3, 8'h07, 4'h0);
    wr(4'd4, 8'h03, 4'h0);
    wr(4'd0, 8'h05, 4'h0);
    for (int i = 0; i < 3; i++) idle(4'h0);
    idle(4'b0010);
    expect_rd(0, 4'd3, 8'h03, "both_status");
    expect_rd(1, 4'd3, 8'h01, "irq_only_status");
    wr(4'd3, 8'h01, 4'h0);
    expect_rd(0, 4'd3, 8'h02, "w1c_status");
    expect_rd(1, 4'd3, 8'h00, "w1c_status");

    // W1C and wake on the same edge: the set wins.
    wr(4'd0, 8'h01, 4'h0);
    wr(4'd3, 8'h07, 4'b0010);
    expect_rd(0, 4'd3, 8'h01, "set_wins");
    expect_rd(1, 4'd3, 8'h01, "set_wins");

    // Lowpower written during sleep applies on wake.
    wr(4'd0, 8'h01, 4'h0);
    wr(4'd0, 8'h03, 4'h0);
    chk("still_sleeping", 0, 32'(slp[0]), 32'd1);
    idle(4'b0010);
    expect_rd(0, 4'd0, 8'h02, "lp_after_wake");
    for (int i = 0; i < 8; i++) idle(4'h0);

    // Reset mid-sleep.
    wr(4'd4, 8'h05, 4'h0);
    wr(4'd0, 8'h01, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midsleep_rst_en", d, 32'(cpu_en[d]), 32'd1);
      chk("midsleep_rst_slp", d, 32'(slp[d]), 32'd0);
      for (int o = 0; o < 6; o++) expect_rd(d, 4'(o), rv[o], "midsleep_rst_reg");
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    // Randomised traffic against the model; timer_en is kept set in every CTRL write.
    for (int i = 0; i < 1500; i++) begin
      r_irq = ($urandom_range(0, 9) == 0) ? NI'($urandom) : '0;
      r = int'($urandom_range(0, 99));
      r_off = 4'($urandom_range(0, 7));
      r_dat = 8'($urandom);
      if (r_off == 4'd0) r_dat[2] = 1'b1;
      if (r_off == 4'd4) r_dat = 8'($urandom_range(0, 20));
      if (r_off == 4'd5) r_dat = 8'h00;
      if (r < 25) step(1'b1, BASE + 16'(r_off), 1'b1, r_dat, r_irq);
      else if (r < 30) step(1'b0, BASE + 16'(r_off), 1'b1, r_dat, r_irq);
      else if (r < 35) step(1'b1, BASE - 16'd1, 1'b0, 8'h00, r_irq);
      else if (r < 60) step(1'b1, BASE + 16'(r_off), 1'b0, 8'h00, r_irq);
      else step(1'b0, 16'h0000, 1'b0, 8'h00, r_irq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reflet_power_manager_ext.md
# reflet_power_manager_ext

Parametrised power manager for the Reflet microcontroller: stops the CPU (sleep) until a masked interrupt or a programmable wake timer expires, or throttles it (low-power) with a PWM duty cycle. It sits on the byte-wide peripheral bus and drives the CPU enable line. Compared to the original manager it adds a configurable interrupt count, a separate mask register, a prescaled wake timer and a sticky wake-cause status register.

## Interface
- base_addr_size, 16, width of bus address
- base_addr, 16'hFF1F, first register address
- int_count, 4, number of interrupt lines, 1..8
- timer_width, 16, wake timer width in bits, multiple of 8, 8..32
- prescale, 1, clock cycles per wake-timer tick, ≥1

- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- enable  in  1  bus enable
- addr  in  base_addr_size  bus address
- write_en  in  1  bus write strobe
- data_in  in  8  write data
- data_out  out  8  read data; 0 when not selected
- cpu_interrupts  in  int_count  interrupt lines, synchronous to clk
- cpu_enable  out  1  CPU clock enable
- sleeping  out  1  high while in SLEEP state

## Operation
- Register map (offset from base_addr, select = enable && offset < 4 + timer_width/8):
  - 0 CTRL: bit0 sleep, bit1 lowpower, bit2 timer_en; bits 7:3 read 0. Reset 0.
  - 1 POWER: PWM duty; reset 8'hFF.
  - 2 MASK: bits int_count-1:0 enable wake per line, others read 0. Reset 0.
  - 3 STATUS: bit0 woke by interrupt, bit1 woke by timer, bit2 woke by CTRL write; sticky, write-1-to-clear. Reset 0.
  - 4.. RELOAD: timer reload, little-endian bytes. Reset 0.
- Reads combinational from current register values.
- States: RUN, LOWPOWER, SLEEP. Reset → RUN.
  - RUN/LOWPOWER: selected by CTRL.lowpower; cpu_enable = 1 in RUN, pwm_out in LOWPOWER.
  - CTRL write with sleep=1 → SLEEP; timer loaded with RELOAD, prescaler cleared.
  - SLEEP: cpu_enable = 0, sleeping = 1. Wake conditions evaluated each edge:
    - int_wake = |(MASK & cpu_interrupts)
    - tmr_wake = timer_en && tick && counter == 0
    - CTRL write with sleep=0 (other bus master)
  - On wake: CTRL.sleep cleared, matching STATUS bits set (all that apply), next state RUN or LOWPOWER per CTRL.lowpower.
- Timer: tick every prescale cycles in SLEEP; on tick, counter==0 → wake, else decrement. Sleep length with timer only = (RELOAD+1)*prescale cycles. timer_en=0 → counter frozen.
- PWM: free-running 8-bit counter from reset; pwm_out = (pwm_cnt <= POWER). Duty = (POWER+1)/256; POWER=FF → constant 1.

## Timing
- All register writes take effect at the edge where write_en is sampled.
- Sleep entry: cpu_enable low in the cycle after the CTRL write edge.
- Wake: condition sampled at edge E → cpu_enable restored (1 or pwm_out) in the cycle after E; sleep cleared at E.
- Interrupt already pending at entry: SLEEP lasts exactly one cycle.
- Simultaneous interrupt and timer expiry: both STATUS bits set.
- STATUS W1C and wake set in same cycle: set wins.
- Write to CTRL with lowpower change while in SLEEP: stored, applied on wake.
- reset asserted anytime (incl. mid-sleep): immediate return to RUN, cpu_enable=1, sleeping=0, all registers to reset values, PWM/timer/prescaler counters to 0.

## Structure
- Shared package: register offsets, CTRL/STATUS bit positions, state encoding (RUN/LOWPOWER/SLEEP).
- One sub-module natural: reflet_power_wake_timer (prescaler + reloadable down-counter, load/enable/expired ports).
- PWM, register file and FSM in the top module.

## Test plan
- Reset: cpu_enable=1, data_out at offset 1 = 8'hFF, offsets 0/2/3 = 0, sleeping=0.
- MASK=4'b0010, CTRL=1; pulse cpu_interrupts[0] → no wake; pulse [1] at edge E → cpu_enable=1 after E, STATUS=8'h01, CTRL reads 0.
- RELOAD=9, prescale=1, CTRL=8'h05 → cpu_enable low exactly 10 cycles, STATUS=8'h02; with prescale=4 → 40 cycles.
- CTRL=2, POWER=8'h3F → cpu_enable high 64 of every 256 cycles; sleep+wake with lowpower set returns to PWM.
- Interrupt and timer expiry on same edge → STATUS=8'h03; write 8'h01 to STATUS → 8'h02.
- Drop reset mid-sleep → cpu_enable=1 asynchronously, all registers at reset values.
